image_crop: RTL and testbench
=============================

IMAGE_CROP -- requirements
Module: image_crop

Interface
REQ-001 Parameter FP_TOTAL, default 16, pixel word width in bits.
REQ-002 Parameter IN_ROWS, default 100, source image rows.
REQ-003 Parameter IN_COLS, default 160, source image columns.
REQ-004 Parameter OUT_ROWS, default 48, crop window rows.
REQ-005 Parameter OUT_COLS, default 48, crop window columns.
REQ-006 Port ap_clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 Port ap_rst_n, input, 1, reset, asynchronous and active-low.
REQ-008 Port ap_start, input, 1, frame start request.
REQ-009 Port ap_ready, output, 1, one-cycle pulse when start is accepted.
REQ-010 Port ap_done, output, 1, one-cycle pulse when frame is complete.
REQ-011 Port ap_idle, output, 1, high while in IDLE.
REQ-012 Port crop_y1, input, $clog2(IN_ROWS), window top row, sampled on start.
REQ-013 Port crop_x1, input, $clog2(IN_COLS), window left column, sampled on start.
REQ-014 Port img_in_TDATA, input, FP_TOTAL, source pixel, raster order (row-major).
REQ-015 Port img_in_TVALID, input, 1, source pixel valid.
REQ-016 Port img_in_TREADY, output, 1, block accepts source pixel.
REQ-017 Port crop_out_TDATA, output, FP_TOTAL, cropped pixel, feeds conv2d_input_V_data_0_V_TDATA.
REQ-018 Port crop_out_TVALID, output, 1, cropped pixel valid.
REQ-019 Port crop_out_TREADY, input, 1, downstream accepts cropped pixel.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, DRAIN; IDLE->RUN on ap_start=1, RUN->DRAIN on acceptance of pixel (IN_ROWS-1, IN_COLS-1), DRAIN->IDLE when output register is empty.
REQ-021 The block SHALL pulse ap_ready in the IDLE->RUN cycle, pulse ap_done in the DRAIN->IDLE cycle, and ignore ap_start outside IDLE.
REQ-022 On start, the block SHALL latch y0=min(crop_y1, IN_ROWS-OUT_ROWS) and x0=min(crop_x1, IN_COLS-OUT_COLS) and clear row/col counters.
REQ-023 A source pixel SHALL transfer only when img_in_TVALID & img_in_TREADY; col counter increments per transfer, wraps IN_COLS-1->0 and increments row.
REQ-024 A pixel is in-window iff y0<=row<y0+OUT_ROWS and x0<=col<x0+OUT_COLS; out-of-window pixels SHALL be discarded.
REQ-025 img_in_TREADY SHALL be 0 in IDLE and DRAIN; in RUN it SHALL be 1 for out-of-window positions and (~crop_out_TVALID | crop_out_TREADY) for in-window positions.
REQ-026 An accepted in-window pixel SHALL appear on crop_out_TDATA with crop_out_TVALID=1 in the next cycle (latency 1), full throughput of one pixel/cycle.
REQ-027 While crop_out_TVALID=1 & crop_out_TREADY=0, crop_out_TDATA SHALL hold stable.
REQ-028 Exactly OUT_ROWS*OUT_COLS output transfers SHALL occur per frame, in raster order of the window.
REQ-029 Simultaneous output handshake and new in-window acceptance SHALL replace the register content with no bubble.
REQ-030 Pixel data SHALL pass bit-exact; no arithmetic on TDATA.

Reset
REQ-031 ap_rst_n=0 SHALL immediately force IDLE, counters 0, crop_out_TVALID=0, crop_out_TDATA=0, ap_done=0, ap_ready=0, ap_idle=1, img_in_TREADY=0.
REQ-032 Reset asserted mid-frame SHALL discard the buffered pixel; the next frame restarts at row 0, col 0.

Structure
REQ-033 Package crop_pkg SHALL hold FP_TOTAL, default image/window dimensions, pixel_t typedef and the state enum.
REQ-034 The output register SHALL be a sub-module axis_out_reg (single-entry register slice with valid/ready pass-through).

Verification
REQ-035 Pixel=row*160+col, crop_y1=10, crop_x1=10, both ready/valid always 1 -> 2304 outputs, first 1610, last 9177, one ap_done.
REQ-036 crop_y1=80, crop_x1=150 -> clamped to y0=52, x0=112; first output 8432, last 15999; DRAIN entered and exited.
REQ-037 crop_out_TREADY=0 for 20 cycles mid-window -> TDATA stable, img_in_TREADY=0 on in-window positions, no loss or duplicate.
REQ-038 Random TVALID/TREADY (50%) for 5 back-to-back frames -> each output sequence matches reference, 5 ap_done pulses.
REQ-039 ap_start pulsed during RUN -> ignored, no ap_ready; ap_rst_n low at row 30 -> outputs cleared, next frame correct from 1610.

Source files
------------

// File: rtl/crop_pkg.sv
// Shared constants and types for the image crop block: default image and
// window geometry, the pixel word type and the frame-control state encoding.
package crop_pkg;

  localparam int FP_TOTAL     = 16;
  localparam int IN_ROWS_DEF  = 100;
  localparam int IN_COLS_DEF  = 160;
  localparam int OUT_ROWS_DEF = 48;
  localparam int OUT_COLS_DEF = 48;

  typedef logic [FP_TOTAL-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-stream register slice. Holds one word, presents it
// downstream, and accepts a new word whenever it is empty or the held word
// leaves in the same cycle, so back-to-back transfers run without bubbles.
module axis_out_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic              vld_q;
  logic              vld_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Room exists when empty or when the current word drains this cycle.
  assign in_ready  = ~vld_q | out_ready;
  assign out_valid = vld_q;
  assign out_data  = data_q;

  // Next-state of the slot: a load wins over a drain so a simultaneous
  // handshake on both sides replaces the content in place.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (in_valid && in_ready) begin
      vld_d  = 1'b1;
      data_d = in_data;
    end else if (out_ready) begin
      vld_d  = 1'b0;
    end
  end

  // Slot storage; reset empties the slot and zeroes the data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/image_crop.sv
// Streaming image crop: consumes a full raster-order frame and forwards only
// the pixels inside an OUT_ROWS x OUT_COLS window whose top-left corner is
// sampled at frame start and clamped so the window always fits the image.
module image_crop #(
  parameter int FP_TOTAL = crop_pkg::FP_TOTAL,
  parameter int IN_ROWS  = crop_pkg::IN_ROWS_DEF,
  parameter int IN_COLS  = crop_pkg::IN_COLS_DEF,
  parameter int OUT_ROWS = crop_pkg::OUT_ROWS_DEF,
  parameter int OUT_COLS = crop_pkg::OUT_COLS_DEF
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       ap_start,
  output logic                       ap_ready,
  output logic                       ap_done,
  output logic                       ap_idle,
  input  logic [$clog2(IN_ROWS)-1:0] crop_y1,
  input  logic [$clog2(IN_COLS)-1:0] crop_x1,
  input  logic [FP_TOTAL-1:0]        img_in_TDATA,
  input  logic                       img_in_TVALID,
  output logic                       img_in_TREADY,
  output logic [FP_TOTAL-1:0]        crop_out_TDATA,
  output logic                       crop_out_TVALID,
  input  logic                       crop_out_TREADY
);

  import crop_pkg::*;

  localparam int RW = $clog2(IN_ROWS);
  localparam int CW = $clog2(IN_COLS);

  localparam logic [RW-1:0] Y0_MAX   = RW'(IN_ROWS - OUT_ROWS);
  localparam logic [CW-1:0] X0_MAX   = CW'(IN_COLS - OUT_COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);
  localparam logic [RW:0]   WIN_H    = (RW+1)'(OUT_ROWS);
  localparam logic [CW:0]   WIN_W    = (CW+1)'(OUT_COLS);

  state_t        state_q;
  state_t        state_d;
  logic [RW-1:0] row_q;
  logic [RW-1:0] row_d;
  logic [CW-1:0] col_q;
  logic [CW-1:0] col_d;
  logic [RW-1:0] y0_q;
  logic [RW-1:0] y0_d;
  logic [CW-1:0] x0_q;
  logic [CW-1:0] x0_d;
  logic          ap_ready_q;
  logic          ap_ready_d;
  logic          ap_done_q;
  logic          ap_done_d;
  logic          ap_idle_q;
  logic          ap_idle_d;

  logic [RW:0]   row_ext;
  logic [RW:0]   y_lo;
  logic [RW:0]   y_hi;
  logic [CW:0]   col_ext;
  logic [CW:0]   x_lo;
  logic [CW:0]   x_hi;
  logic          in_win;
  logic          last_pix;
  logic          slot_ready;
  logic          src_ready;
  logic          src_xfer;
  logic          slot_load;

  // Window membership of the current raster position; one extra bit keeps
  // the exclusive upper bound from wrapping.
  always_comb begin
    row_ext  = {1'b0, row_q};
    col_ext  = {1'b0, col_q};
    y_lo     = {1'b0, y0_q};
    x_lo     = {1'b0, x0_q};
    y_hi     = y_lo + WIN_H;
    x_hi     = x_lo + WIN_W;
    in_win   = (row_ext >= y_lo) && (row_ext < y_hi) &&
               (col_ext >= x_lo) && (col_ext < x_hi);
    last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  // Source handshake: discarded pixels are always taken, window pixels only
  // when the output slot has room.
  always_comb begin
    src_ready = 1'b0;
    if (state_q == ST_RUN) begin
      src_ready = in_win ? slot_ready : 1'b1;
    end
    src_xfer  = src_ready & img_in_TVALID;
    slot_load = src_xfer & in_win;
  end

  assign img_in_TREADY = src_ready;

  // Frame control next-state: window origin capture, raster counters and
  // the start/done handshake pulses.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    y0_d       = y0_q;
    x0_d       = x0_q;
    ap_ready_d = 1'b0;
    ap_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          state_d    = ST_RUN;
          y0_d       = (crop_y1 > Y0_MAX) ? Y0_MAX : crop_y1;
          x0_d       = (crop_x1 > X0_MAX) ? X0_MAX : crop_x1;
          row_d      = '0;
          col_d      = '0;
          ap_ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (src_xfer) begin
          if (last_pix) begin
            state_d = ST_DRAIN;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!crop_out_TVALID) begin
          state_d   = ST_IDLE;
          ap_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ap_idle_d = (state_d == ST_IDLE);
  end

  // Frame control FSM with registered status outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      y0_q       <= '0;
      x0_q       <= '0;
      ap_ready_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_idle_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      y0_q       <= y0_d;
      x0_q       <= x0_d;
      ap_ready_q <= ap_ready_d;
      ap_done_q  <= ap_done_d;
      ap_idle_q  <= ap_idle_d;
    end
  end

  assign ap_ready = ap_ready_q;
  assign ap_done  = ap_done_q;
  assign ap_idle  = ap_idle_q;

  axis_out_reg #(
    .DATA_W (FP_TOTAL)
  ) u_out_reg (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .in_data   (img_in_TDATA),
    .in_valid  (slot_load),
    .in_ready  (slot_ready),
    .out_data  (crop_out_TDATA),
    .out_valid (crop_out_TVALID),
    .out_ready (crop_out_TREADY)
  );

endmodule

// File: tb/tb_image_crop.sv
// Bench for image_crop: a default-size instance runs directed frames
// (plain crop, clamped crop, mid-frame reset, output stall) and a small
// instance runs five back-to-back frames with random handshakes. Expected
// window pixels come from a geometric model and are checked by monitors.
module tb_image_crop;

  localparam int A_R = 100, A_C = 160, A_OR = 48, A_OC = 48;
  localparam int B_R = 12,  B_C = 10,  B_OR = 5,  B_OC = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instance A (default geometry) ----------------
  logic        a_rst_n = 1'b0, a_start = 1'b0, a_ready, a_done, a_idle;
  logic [6:0]  a_y1 = '0;
  logic [7:0]  a_x1 = '0;
  logic [15:0] a_in_data = '0, a_out_data;
  logic        a_in_vld = 1'b0, a_in_rdy, a_out_vld, a_out_rdy = 1'b1;

  image_crop u_a (
    .ap_clk(clk), .ap_rst_n(a_rst_n), .ap_start(a_start), .ap_ready(a_ready),
    .ap_done(a_done), .ap_idle(a_idle), .crop_y1(a_y1), .crop_x1(a_x1),
    .img_in_TDATA(a_in_data), .img_in_TVALID(a_in_vld), .img_in_TREADY(a_in_rdy),
    .crop_out_TDATA(a_out_data), .crop_out_TVALID(a_out_vld),
    .crop_out_TREADY(a_out_rdy)
  );

  int a_exp[$];
  int a_out_cnt = 0, a_done_cnt = 0, a_rdy_cnt = 0, a_first = -1, a_last = -1;
  int a_idx = -1, a_e = 0, a_hold_data = 0;
  bit a_hold = 0;

  always @(negedge clk) begin
    if (!a_rst_n) begin
      a_hold = 0;
    end else begin
      if (a_hold) check("a_hold_data", int'(a_out_data), a_hold_data);
      if (a_out_vld && a_out_rdy) begin
        if (a_exp.size() == 0) check("a_unexpected_out", int'(a_out_data), -1);
        else begin
          a_e = a_exp.pop_front();
          check("a_pixel", int'(a_out_data), a_e);
        end
        if (a_out_cnt == 0) a_first = int'(a_out_data);
        a_last = int'(a_out_data);
        a_out_cnt++;
      end
      if (a_done)  a_done_cnt++;
      if (a_ready) a_rdy_cnt++;
      a_hold      = a_out_vld && !a_out_rdy;
      a_hold_data = int'(a_out_data);
    end
  end

  // Window pixels of a frame whose value is row*A_C+col, limited to indices < lim.
  task automatic a_push(input int y1, input int x1, input int lim);
    int y0, x0;
    y0 = (y1 > A_R - A_OR) ? A_R - A_OR : y1;
    x0 = (x1 > A_C - A_OC) ? A_C - A_OC : x1;
    for (int r = y0; r < y0 + A_OR; r++)
      for (int c = x0; c < x0 + A_OC; c++)
        if (r * A_C + c < lim) a_exp.push_back(r * A_C + c);
  endtask

  task automatic a_go(input int y1, input int x1);
    a_out_cnt = 0; a_done_cnt = 0; a_rdy_cnt = 0; a_first = -1; a_last = -1;
    a_y1 = 7'(y1); a_x1 = 8'(x1);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("a_ap_ready_pulse", int'(a_ready), 1);
    check("a_ap_idle_run", int'(a_idle), 0);
  endtask

  task automatic a_feed(input int n_pix, input int start_idx);
    int budget;
    bit ok;
    for (int i = 0; i < n_pix; i++) begin
      a_idx = i;
      a_in_data = 16'(i);
      a_in_vld = 1'b1;
      a_start = (i == start_idx);
      budget = 0;
      do begin
        @(negedge clk); ok = a_in_rdy;
        @(posedge clk); #1;
        a_start = 1'b0;
        budget++;
      end while (!ok && budget < 100);
      if (!ok) begin
        check("a_input_timeout", 0, 1);
        a_in_vld = 1'b0; a_idx = -1;
        return;
      end
    end
    a_in_vld = 1'b0;
    a_idx = -1;
  endtask

  task automatic a_wait_done();
    for (int k = 0; k < 100 && a_done_cnt == 0; k++) begin
      @(posedge clk); #1;
    end
    check("a_done_count", a_done_cnt, 1);
    check("a_leftover_expected", a_exp.size(), 0);
    check("a_out_count", a_out_cnt, A_OR * A_OC);
    check("a_ready_count", a_rdy_cnt, 1);
    check("a_idle_after", int'(a_idle), 1);
  endtask

  task automatic a_stall(input int at_idx);
    wait (a_idx == at_idx);
    a_out_rdy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("a_stall_in_ready", int'(a_in_rdy), 0);
      check("a_stall_out_valid", int'(a_out_vld), 1);
    end
    @(posedge clk); #1;
    a_out_rdy = 1'b1;
  endtask

  task automatic a_sequence();
    a_push(10, 10, A_R * A_C);
    a_go(10, 10);
    a_feed(A_R * A_C, -1);
    a_wait_done();
    check("a_f1_first", a_first, 1610);
    check("a_f1_last", a_last, 9177);

    a_push(80, 150, A_R * A_C);
    a_go(80, 150);
    a_feed(A_R * A_C, -1);
    a_wait_done();
    check("a_f2_first", a_first, 8432);
    check("a_f2_last", a_last, 15999);

    // Start pulsed mid-frame, then reset right after (30,19) enters the slot.
    a_push(10, 10, 30 * A_C + 19);
    a_go(10, 10);
    a_feed(30 * A_C + 20, 100);
    a_rst_n = 1'b0;
    #1;
    check("a_rst_out_valid", int'(a_out_vld), 0);
    check("a_rst_out_data", int'(a_out_data), 0);
    check("a_rst_idle", int'(a_idle), 1);
    check("a_rst_in_ready", int'(a_in_rdy), 0);
    check("a_rst_ap_ready", int'(a_ready), 0);
    check("a_rst_ap_done", int'(a_done), 0);
    check("a_rst_leftover", a_exp.size(), 0);
    check("a_start_ignored", a_rdy_cnt, 1);
    a_exp.delete();
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    @(posedge clk); #1;

    a_push(10, 10, A_R * A_C);
    a_go(10, 10);
    fork
      a_feed(A_R * A_C, -1);
      a_stall(30 * A_C + 20);
    join
    a_wait_done();
    check("a_f4_first", a_first, 1610);
    check("a_f4_last", a_last, 9177);
  endtask

  // ---------------- instance B (small geometry, random traffic) ----------------
  logic        b_rst_n = 1'b0, b_start = 1'b0, b_ready, b_done, b_idle;
  logic [3:0]  b_y1 = '0, b_x1 = '0;
  logic [15:0] b_in_data = '0, b_out_data;
  logic        b_in_vld = 1'b0, b_in_rdy, b_out_vld, b_out_rdy = 1'b1;
  bit          b_rand = 0;

  image_crop #(
    .FP_TOTAL(16), .IN_ROWS(B_R), .IN_COLS(B_C), .OUT_ROWS(B_OR), .OUT_COLS(B_OC)
  ) u_b (
    .ap_clk(clk), .ap_rst_n(b_rst_n), .ap_start(b_start), .ap_ready(b_ready),
    .ap_done(b_done), .ap_idle(b_idle), .crop_y1(b_y1), .crop_x1(b_x1),
    .img_in_TDATA(b_in_data), .img_in_TVALID(b_in_vld), .img_in_TREADY(b_in_rdy),
    .crop_out_TDATA(b_out_data), .crop_out_TVALID(b_out_vld),
    .crop_out_TREADY(b_out_rdy)
  );

  int b_exp[$];
  int b_pix[B_R * B_C];
  int b_out_cnt = 0, b_done_cnt = 0, b_e = 0, b_hold_data = 0;
  bit b_hold = 0;

  initial forever begin
    @(posedge clk); #1;
    if (b_rand) b_out_rdy = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!b_rst_n) begin
      b_hold = 0;
    end else begin
      if (b_hold) begin
        check("b_hold_data", int'(b_out_data), b_hold_data);
        check("b_hold_valid", int'(b_out_vld), 1);
      end
      if (b_out_vld && b_out_rdy) begin
        if (b_exp.size() == 0) check("b_unexpected_out", int'(b_out_data), -1);
        else begin
          b_e = b_exp.pop_front();
          check("b_pixel", int'(b_out_data), b_e);
        end
        b_out_cnt++;
      end
      if (b_done) b_done_cnt++;
      b_hold      = b_out_vld && !b_out_rdy;
      b_hold_data = int'(b_out_data);
    end
  end

  task automatic b_sequence();
    int y1, x1, y0, x0, budget;
    bit ok;
    b_rand = 1;
    for (int f = 0; f < 5; f++) begin
      y1 = $urandom_range(0, 15);
      x1 = $urandom_range(0, 15);
      for (int i = 0; i < B_R * B_C; i++) b_pix[i] = $urandom_range(0, 65535);
      y0 = (y1 > B_R - B_OR) ? B_R - B_OR : y1;
      x0 = (x1 > B_C - B_OC) ? B_C - B_OC : x1;
      for (int r = y0; r < y0 + B_OR; r++)
        for (int c = x0; c < x0 + B_OC; c++)
          b_exp.push_back(b_pix[r * B_C + c]);
      b_out_cnt = 0;
      b_y1 = 4'(y1); b_x1 = 4'(x1);
      b_start = 1'b1;
      ok = 0;
      for (int k = 0; k < 10 && !ok; k++) begin
        @(posedge clk); #1;
        ok = b_ready;
      end
      b_start = 1'b0;
      check("b_ap_ready_pulse", int'(ok), 1);
      for (int i = 0; i < B_R * B_C; i++) begin
        b_in_data = 16'(b_pix[i]);
        budget = 0;
        do begin
          b_in_vld = 1'($urandom_range(0, 1));
          @(negedge clk); ok = b_in_vld && b_in_rdy;
          @(posedge clk); #1;
          budget++;
        end while (!ok && budget < 200);
        if (!ok) begin
          check("b_input_timeout", 0, 1);
          break;
        end
      end
      b_in_vld = 1'b0;
      for (int k = 0; k < 300 && b_done_cnt < f + 1; k++) begin
        @(posedge clk); #1;
      end
      check("b_done_count", b_done_cnt, f + 1);
      check("b_out_count", b_out_cnt, B_OR * B_OC);
      check("b_leftover_expected", b_exp.size(), 0);
      b_exp.delete();
    end
    check("b_total_done", b_done_cnt, 5);
    b_rand = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_idle", int'(a_idle), 1);
    check("a_reset_out_valid", int'(a_out_vld), 0);
    check("a_reset_out_data", int'(a_out_data), 0);
    check("a_reset_in_ready", int'(a_in_rdy), 0);
    check("a_reset_ap_ready", int'(a_ready), 0);
    check("a_reset_ap_done", int'(a_done), 0);
    check("b_reset_idle", int'(b_idle), 1);
    check("b_reset_out_valid", int'(b_out_vld), 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(posedge clk); #1;
    check("a_idle_no_start", int'(a_in_rdy), 0);
    fork
      a_sequence();
      b_sequence();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
